// File: rtl/name_issue_scheduler.sv
// name_issue_scheduler: grants whole names to one of two lanes (idle-first, round-robin)
// and streams each name word by word into its lane, holding every word HOLD_CYCLES unstalled clocks.
module name_issue_scheduler #(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_NAME_LENGTH = 8,
    parameter int WORD_IDX_SIZE   = 3,
    parameter int LEN_SIZE        = 4,
    parameter int HOLD_CYCLES     = 2,
    parameter int COUNT_SIZE      = 16
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic [WORD_SIZE*MAX_NAME_LENGTH-1:0] name_in,
    input  logic [LEN_SIZE-1:0]                  name_len_in,
    input  logic                                 name_valid_in,
    output logic                                 name_ready_out,
    input  logic                                 lane_stall_in_1,
    input  logic                                 lane_stall_in_2,
    output logic [WORD_SIZE-1:0]                 lane_word_out_1,
    output logic [WORD_SIZE-1:0]                 lane_word_out_2,
    output logic                                 lane_valid_out_1,
    output logic                                 lane_valid_out_2,
    output logic [WORD_IDX_SIZE-1:0]             lane_idx_out_1,
    output logic [WORD_IDX_SIZE-1:0]             lane_idx_out_2,
    output logic                                 lane_first_out_1,
    output logic                                 lane_first_out_2,
    output logic                                 lane_last_out_1,
    output logic                                 lane_last_out_2,
    output logic [COUNT_SIZE-1:0]                issued_count_out_1,
    output logic [COUNT_SIZE-1:0]                issued_count_out_2,
    output logic [COUNT_SIZE-1:0]                drop_count_out
);
    localparam int NW = WORD_SIZE * MAX_NAME_LENGTH;
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    typedef enum logic {IDLE, ISSUE} state_t;
    logic [1:0] idle, grant, stall;
    logic rr, accept, zero;
    logic [LEN_SIZE-1:0] eff_len;
    logic [COUNT_SIZE-1:0] drop;
    assign stall          = {lane_stall_in_2, lane_stall_in_1};
    assign name_ready_out = |idle;
    assign accept         = name_valid_in && name_ready_out;
    assign zero           = name_len_in == '0;
    assign eff_len        = name_len_in > LEN_SIZE'(MAX_NAME_LENGTH) ? LEN_SIZE'(MAX_NAME_LENGTH) : name_len_in;
    // rr=0 favours lane 1 when both lanes are idle
    assign grant[0] = accept && !zero && idle[0] && (!idle[1] || !rr);
    assign grant[1] = accept && !zero && idle[1] && (!idle[0] || rr);
    assign drop_count_out = drop;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr   <= 1'b0;
            drop <= '0;
        end else begin
            if (grant[0]) rr <= 1'b1;
            else if (grant[1]) rr <= 1'b0;
            if (accept && zero) drop <= drop + 1'b1;
        end
    end
    for (genvar g = 0; g < 2; g++) begin : g_lane
        state_t st, st_nx;
        logic [NW-1:0] name_q;
        logic [LEN_SIZE-1:0] len_q;
        logic [WORD_IDX_SIZE-1:0] idx, idx_nx;
        logic [HW-1:0] hold, hold_nx;
        logic [COUNT_SIZE-1:0] issued;
        logic [WORD_SIZE-1:0] word;
        logic busy, first, last, done;
        assign idle[g] = st == IDLE;
        assign busy    = st == ISSUE;
        assign first   = busy && idx == '0;
        assign last    = busy && LEN_SIZE'(idx) == len_q - 1'b1;
        assign word    = busy ? name_q[WORD_SIZE*(MAX_NAME_LENGTH-1-int'(idx)) +: WORD_SIZE] : '0;
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                st     <= IDLE;
                idx    <= '0;
                hold   <= '0;
                name_q <= '0;
                len_q  <= '0;
                issued <= '0;
            end else begin
                st   <= st_nx;
                idx  <= idx_nx;
                hold <= hold_nx;
                if (grant[g]) begin
                    name_q <= name_in;
                    len_q  <= eff_len;
                end
                if (done) issued <= issued + 1'b1;
            end
        end
        always_comb begin
            st_nx   = st;
            idx_nx  = idx;
            hold_nx = hold;
            done    = 1'b0;
            if (grant[g]) begin
                st_nx   = ISSUE;
                idx_nx  = '0;
                hold_nx = '0;
            end else if (busy && !stall[g]) begin
                if (hold == HW'(HOLD_CYCLES - 1)) begin
                    hold_nx = '0;
                    idx_nx  = last ? '0 : idx + 1'b1;
                    st_nx   = last ? IDLE : ISSUE;
                    done    = last;
                end else begin
                    hold_nx = hold + 1'b1;
                end
            end
        end
    end
    assign lane_word_out_1    = g_lane[0].word;
    assign lane_word_out_2    = g_lane[1].word;
    assign lane_valid_out_1   = g_lane[0].busy;
    assign lane_valid_out_2   = g_lane[1].busy;
    assign lane_idx_out_1     = g_lane[0].idx;
    assign lane_idx_out_2     = g_lane[1].idx;
    assign lane_first_out_1   = g_lane[0].first;
    assign lane_first_out_2   = g_lane[1].first;
    assign lane_last_out_1    = g_lane[0].last;
    assign lane_last_out_2    = g_lane[1].last;
    assign issued_count_out_1 = g_lane[0].issued;
    assign issued_count_out_2 = g_lane[1].issued;
endmodule

// File: tb/tb_name_issue_scheduler.sv
// tb_name_issue_scheduler: scoreboard bench; each accepted name is expanded into per-cycle
// expected beats queued per lane, popped as the lane advances, and compared every cycle.
module tb_name_issue_scheduler;
    localparam int W = 32, M = 8, IW = 3, LW = 4, H = 2, CW = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic [W*M-1:0] name = '0;
    logic [LW-1:0] len = '0;
    logic valid = 1'b0, ready, s1 = 1'b0, s2 = 1'b0;
    logic [W-1:0] w1, w2;
    logic v1, v2, f1, f2, l1, l2;
    logic [IW-1:0] i1, i2;
    logic [CW-1:0] c1, c2, cd;

    always #5 clk = ~clk;

    name_issue_scheduler dut (
        .clk_in(clk), .rst_in(rst), .name_in(name), .name_len_in(len),
        .name_valid_in(valid), .name_ready_out(ready),
        .lane_stall_in_1(s1), .lane_stall_in_2(s2),
        .lane_word_out_1(w1), .lane_word_out_2(w2),
        .lane_valid_out_1(v1), .lane_valid_out_2(v2),
        .lane_idx_out_1(i1), .lane_idx_out_2(i2),
        .lane_first_out_1(f1), .lane_first_out_2(f2),
        .lane_last_out_1(l1), .lane_last_out_2(l2),
        .issued_count_out_1(c1), .issued_count_out_2(c2),
        .drop_count_out(cd)
    );

    typedef struct packed {
        logic [W-1:0]  w;
        logic [IW-1:0] i;
        logic          f;
        logic          l;
    } beat_t;

    beat_t q0[$], q1[$];
    int errors = 0, checks = 0;
    int rr_m = 0;
    logic [CW-1:0] iss0 = '0, iss1 = '0, drop_m = '0;
    bit acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: compare this cycle's outputs, drive inputs for the coming edge, advance the model
    task automatic step(input logic v, input logic [W*M-1:0] nm, input logic [LW-1:0] ln,
                        input logic st1, input logic st2, input logic r);
        bit e0, e1;
        beat_t b, h0, h1;
        int lane, eff;
        @(negedge clk);
        h0 = q0.size() != 0 ? q0[0] : '0;
        h1 = q1.size() != 0 ? q1[0] : '0;
        check("lane1", {v1, w1, i1, f1, l1}, q0.size() != 0 ? {1'b1, h0} : 39'd0);
        check("lane2", {v2, w2, i2, f2, l2}, q1.size() != 0 ? {1'b1, h1} : 39'd0);
        check("ready", ready, q0.size() == 0 || q1.size() == 0);
        check("issued1", c1, iss0);
        check("issued2", c2, iss1);
        check("drop", cd, drop_m);
        valid = v; name = nm; len = ln; s1 = st1; s2 = st2; rst = r;
        acc = 0;
        if (r) begin
            q0.delete(); q1.delete();
            iss0 = '0; iss1 = '0; drop_m = '0; rr_m = 0;
        end else begin
            e0 = q0.size() == 0;
            e1 = q1.size() == 0;
            if (!e0 && !st1) begin
                b = q0.pop_front();
                if (q0.size() == 0) iss0++;
            end
            if (!e1 && !st2) begin
                b = q1.pop_front();
                if (q1.size() == 0) iss1++;
            end
            if (v && (e0 || e1)) begin
                acc = 1;
                if (ln == 0) drop_m++;
                else begin
                    lane = (e0 && e1) ? rr_m : (e0 ? 0 : 1);
                    rr_m = 1 - lane;
                    eff = ln > M ? M : int'(ln);
                    for (int k = 0; k < eff; k++)
                        for (int hc = 0; hc < H; hc++) begin
                            b.w = nm[W*(M-k)-1 -: W];
                            b.i = IW'(k);
                            b.f = k == 0;
                            b.l = k == eff - 1;
                            if (lane == 0) q0.push_back(b); else q1.push_back(b);
                        end
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic st1 = 0, input logic st2 = 0);
        repeat (n) step(0, '0, '0, st1, st2, 0);
    endtask

    task automatic offer(input logic [W*M-1:0] nm, input int ln);
        bit got = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            step(1, nm, LW'(ln), 0, 0, 0);
            got = acc;
        end
        if (!got) check("offer_timeout", 0, 1);
    endtask

    function automatic logic [W*M-1:0] seq_name();
        logic [W*M-1:0] nm;
        for (int k = 0; k < M; k++) nm[W*(M-k)-1 -: W] = 32'h11111111 * (k + 1);
        return nm;
    endfunction

    function automatic logic [W*M-1:0] rnd_name();
        logic [W*M-1:0] nm;
        for (int k = 0; k < M; k++) nm[W*(M-k)-1 -: W] = $urandom();
        return nm;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        idle(3);
        offer(seq_name(), 8);
        idle(20);
        offer(rnd_name(), 8);
        offer(rnd_name(), 8);
        offer(rnd_name(), 8);
        idle(20);
        offer(rnd_name(), 3);
        offer(rnd_name(), 0);
        offer(rnd_name(), 12);
        idle(20);
        step(0, '0, '0, 0, 0, 1);
        offer(rnd_name(), 8);
        offer(rnd_name(), 8);
        idle(3);
        idle(3, 1, 0);
        idle(25);
        offer(rnd_name(), 8);
        offer(rnd_name(), 8);
        idle(8);
        step(0, '0, '0, 0, 0, 1);
        idle(2);
        offer(seq_name(), 5);
        idle(15);
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, rnd_name(), LW'($urandom_range(0, 12)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, 0);
        idle(40);
        check("drained", q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
